// File: rtl/cheb_poly_eva_param.sv
// rtl/cheb_poly_eva_param.sv - Chebyshev polynomial evaluator sharing an external multiplier

// Sign-magnitude adder used for both the recurrence step and the accumulation
module cheb_poly_sm_add #(
   parameter int N   = 32,
   parameter bit SAT = 1'b1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   logic [N-2:0] a_mag;
   logic [N-2:0] b_mag;
   logic [N-2:0] big_mag;
   logic [N-2:0] small_mag;
   logic [N-2:0] res_mag;
   logic         a_sgn;
   logic         b_sgn;
   logic         res_sgn;
   logic [N-1:0] mag_sum;

   // Negative zero operands are folded to +0 so the sign comparison is meaningful;
   // a zero result is always reported with a positive sign
   always_comb begin
      a_mag     = a[N-2:0];
      b_mag     = b[N-2:0];
      a_sgn     = a[N-1] & (|a_mag);
      b_sgn     = b[N-1] & (|b_mag);
      mag_sum   = {1'b0, a_mag} + {1'b0, b_mag};
      big_mag   = a_mag;
      small_mag = b_mag;
      res_sgn   = a_sgn;
      res_mag   = '0;
      if (a_sgn == b_sgn) begin
         res_sgn = a_sgn;
         if (mag_sum[N-1] && SAT) begin
            res_mag = '1;
         end else begin
            res_mag = mag_sum[N-2:0];
         end
      end else begin
         if (a_mag >= b_mag) begin
            big_mag   = a_mag;
            small_mag = b_mag;
            res_sgn   = a_sgn;
         end else begin
            big_mag   = b_mag;
            small_mag = a_mag;
            res_sgn   = b_sgn;
         end
         res_mag = big_mag - small_mag;
      end
      y = {res_sgn & (|res_mag), res_mag};
   end

endmodule

// Evaluates sum = coeff[ORDER-k] * T_k(x) over k = 0..ORDER with T_k = 2x*T_{k-1} - T_{k-2}
module cheb_poly_eva_param #(
   parameter int N     = 32,
   parameter int Q     = 16,
   parameter int ORDER = 5,
   parameter bit SAT   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   startcp,
   input  logic [N-1:0]           x,
   input  logic [(ORDER+1)*N-1:0] coeff,
   input  logic [N-1:0]           out_mult,
   input  logic                   mult_ack,
   output logic [N-1:0]           mult1,
   output logic [N-1:0]           mult2,
   output logic                   mult_req,
   output logic [N-1:0]           sum,
   output logic                   busy,
   output logic                   donecp
);

   localparam int          KW  = $clog2(ORDER + 2);
   localparam logic [N-1:0] ONE = N'(1) << Q;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MUL_T,
      S_ADD_T,
      S_MUL_C,
      S_ACC,
      S_DONE
   } state_t;

   state_t                 state;
   logic [N-1:0]           x_r;
   logic [(ORDER+1)*N-1:0] coeff_sh;
   logic [N-1:0]           tm1;
   logic [N-1:0]           tm2;
   logic [N-1:0]           x2;
   logic [N-1:0]           prod;
   logic [KW-1:0]          k;

   logic [N-1:0]           add_a;
   logic [N-1:0]           add_b;
   logic [N-1:0]           add_y;

   // One adder serves both uses: ACC adds the product into sum, ADD_T forms p - T_{k-2}
   always_comb begin
      add_a = prod;
      add_b = {~tm2[N-1], tm2[N-2:0]};
      if (state == S_ACC) begin
         add_a = sum;
         add_b = prod;
      end
   end

   cheb_poly_sm_add #(
      .N   (N),
      .SAT (SAT)
   ) u_add (
      .a (add_a),
      .b (add_b),
      .y (add_y)
   );

   // Control FSM; coefficients sit in a shift register so the top word is always coeff[ORDER-k]
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         x_r      <= '0;
         coeff_sh <= '0;
         tm1      <= '0;
         tm2      <= '0;
         x2       <= '0;
         prod     <= '0;
         k        <= '0;
         mult1    <= '0;
         mult2    <= '0;
         mult_req <= 1'b0;
         sum      <= '0;
         busy     <= 1'b0;
         donecp   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (startcp) begin
                  x_r      <= x;
                  coeff_sh <= coeff;
                  sum      <= '0;
                  busy     <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               tm2      <= ONE;
               tm1      <= x_r;
               // Doubling keeps the sign and drops the magnitude MSB, no saturation
               x2       <= {x_r[N-1], x_r[N-3:0], 1'b0};
               k        <= '0;
               mult1    <= coeff_sh[ORDER*N +: N];
               mult2    <= ONE;
               mult_req <= 1'b1;
               state    <= S_MUL_C;
            end
            S_MUL_T: begin
               if (mult_req && mult_ack) begin
                  prod     <= out_mult;
                  mult_req <= 1'b0;
                  state    <= S_ADD_T;
               end
            end
            S_ADD_T: begin
               tm2      <= tm1;
               tm1      <= add_y;
               mult1    <= coeff_sh[ORDER*N +: N];
               mult2    <= add_y;
               mult_req <= 1'b1;
               state    <= S_MUL_C;
            end
            S_MUL_C: begin
               if (mult_req && mult_ack) begin
                  prod     <= out_mult;
                  mult_req <= 1'b0;
                  state    <= S_ACC;
               end
            end
            S_ACC: begin
               sum      <= add_y;
               coeff_sh <= coeff_sh << N;
               if (k == KW'(ORDER)) begin
                  donecp <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  k        <= k + 1'b1;
                  mult_req <= 1'b1;
                  if (k == '0) begin
                     // T_1 = x is used directly, no recurrence step
                     mult1 <= coeff_sh[(ORDER-1)*N +: N];
                     mult2 <= tm1;
                     state <= S_MUL_C;
                  end else begin
                     mult1 <= tm1;
                     mult2 <= x2;
                     state <= S_MUL_T;
                  end
               end
            end
            S_DONE: begin
               donecp <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cheb_poly_eva_param.sv
// tb/tb_cheb_poly_eva_param.sv - scoreboard bench for cheb_poly_eva_param
`timescale 1ns/1ps
module tb_cheb_poly_eva_param;

   localparam int N   = 32;
   localparam int Q   = 16;
   localparam int ORD = 5;
   localparam int CW  = (ORD + 1) * N;
   localparam logic [N-1:0] ONE  = 32'h0001_0000;
   localparam logic [N-1:0] HALF = 32'h0000_8000;
   localparam longint MAXM = 64'h7FFF_FFFF;
   localparam longint MODM = 64'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // main instance: ORDER=5, SAT=1, randomised multiplier latency
   logic          startcp = 1'b0;
   logic [N-1:0]  x = '0;
   logic [CW-1:0] coeff = '0;
   logic [N-1:0]  out_mult;
   logic          mult_ack = 1'b0;
   logic [N-1:0]  mult1, mult2, sum;
   logic          mult_req, busy, donecp;

   // SAT=0 instance
   logic          startb = 1'b0;
   logic [N-1:0]  xb = '0;
   logic [CW-1:0] coeffb = '0;
   logic [N-1:0]  outb, m1b, m2b, sumb;
   logic          reqb, busyb, doneb;

   // ORDER=1 instance
   logic           startc = 1'b0;
   logic [N-1:0]   xc = '0;
   logic [2*N-1:0] coeffc = '0;
   logic [N-1:0]   outc, m1c, m2c, sumc;
   logic           reqc, busyc, donec;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic longint sm2i(input logic [N-1:0] v);
      return v[N-1] ? -longint'(v[N-2:0]) : longint'(v[N-2:0]);
   endfunction

   function automatic logic [N-1:0] i2sm(input longint r, input bit sat);
      longint mag;
      mag = (r < 0) ? -r : r;
      if (mag > MAXM) mag = sat ? MAXM : (mag % MODM);
      if (mag == 0) return '0;
      return {(r < 0), mag[30:0]};
   endfunction

   function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [63:0]  p;
      logic [N-2:0] m;
      p = (64'(a[N-2:0]) * 64'(b[N-2:0])) >> Q;
      m = p[N-2:0];
      if (m == '0) return '0;
      return {a[N-1] ^ b[N-1], m};
   endfunction

   function automatic logic [N-1:0] ref_eval(input logic [N-1:0] xv, input logic [CW-1:0] cv,
                                             input int order, input bit sat);
      logic [N-1:0] tm1, tm2, tk, acc, x2, t;
      x2  = {xv[N-1], 31'(xv[N-2:0] * 2)};
      tm2 = ONE;
      tm1 = xv;
      acc = '0;
      tk  = ONE;
      for (int k = 0; k <= order; k++) begin
         if (k == 0) tk = ONE;
         else if (k == 1) tk = xv;
         else begin
            t   = i2sm(sm2i(fmul(tm1, x2)) - sm2i(tm2), sat);
            tm2 = tm1;
            tm1 = t;
            tk  = t;
         end
         acc = i2sm(sm2i(acc) + sm2i(fmul(cv[(order-k)*N +: N], tk)), sat);
      end
      return acc;
   endfunction

   function automatic logic [CW-1:0] mk(input logic [N-1:0] c5, c4, c3, c2, c1, c0);
      return {c5, c4, c3, c2, c1, c0};
   endfunction

   function automatic logic [N-1:0] rnd_word(input int unsigned lim);
      return {1'($urandom_range(1, 0)), 31'($urandom_range(lim, 0))};
   endfunction

   // ---------------- DUTs ----------------
   cheb_poly_eva_param #(.N(N), .Q(Q), .ORDER(ORD), .SAT(1'b1)) dut (
      .clk(clk), .rst(rst), .startcp(startcp), .x(x), .coeff(coeff),
      .out_mult(out_mult), .mult_ack(mult_ack), .mult1(mult1), .mult2(mult2),
      .mult_req(mult_req), .sum(sum), .busy(busy), .donecp(donecp)
   );

   cheb_poly_eva_param #(.N(N), .Q(Q), .ORDER(ORD), .SAT(1'b0)) dut_nosat (
      .clk(clk), .rst(rst), .startcp(startb), .x(xb), .coeff(coeffb),
      .out_mult(outb), .mult_ack(reqb), .mult1(m1b), .mult2(m2b),
      .mult_req(reqb), .sum(sumb), .busy(busyb), .donecp(doneb)
   );

   cheb_poly_eva_param #(.N(N), .Q(Q), .ORDER(1), .SAT(1'b1)) dut_ord1 (
      .clk(clk), .rst(rst), .startcp(startc), .x(xc), .coeff(coeffc),
      .out_mult(outc), .mult_ack(reqc), .mult1(m1c), .mult2(m2c),
      .mult_req(reqc), .sum(sumc), .busy(busyc), .donecp(donec)
   );

   assign out_mult = fmul(mult1, mult2);
   assign outb     = fmul(m1b, m2b);
   assign outc     = fmul(m1c, m2c);

   // ---------------- shared multiplier model with random ack delay ----------------
   int max_wait = 0;
   int wait_acc = 0;
   int wcnt = 0;
   bit pending = 1'b0;
   bit spurious_en = 1'b0;

   always @(negedge clk) begin
      if (mult_req) begin
         if (!pending) begin
            pending = 1'b1;
            wcnt = $urandom_range(max_wait, 0);
            wait_acc += wcnt;
         end
         if (wcnt == 0) begin
            mult_ack = 1'b1;
            pending = 1'b0;
         end else begin
            mult_ack = 1'b0;
            wcnt--;
         end
      end else begin
         pending = 1'b0;
         mult_ack = spurious_en ? 1'($urandom_range(1, 0)) : 1'b0;
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [N-1:0] exp_q[$];
   logic [N-1:0] exp_v;
   int n_done = 0;
   int start_cyc = 0;
   bit post_chk = 1'b0;
   bit prev_req = 1'b0, prev_ack = 1'b0, prev_ok = 1'b0;
   logic [N-1:0] prev_m1 = '0, prev_m2 = '0;

   always @(negedge clk) begin
      #1;
      if (post_chk) begin
         post_chk = 1'b0;
         chk("donecp_pulse_width", 32'(donecp), 32'd0);
         chk("busy_after_done", 32'(busy), 32'd0);
      end else if (!rst && donecp) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got donecp=1 expected no pending result");
         end else begin
            exp_v = exp_q.pop_front();
            chk("sum", sum, exp_v);
            chk("done_cycle", 32'(cyc - start_cyc), 32'(4 * ORD + 2 + wait_acc));
            chk("busy_at_done", 32'(busy), 32'd1);
         end
         n_done++;
         post_chk = 1'b1;
      end
      // handshake: operands and request held until ack is taken, request low right after
      if (!rst && prev_ok && prev_req) begin
         if (prev_ack) begin
            chk("req_drop_after_ack", 32'(mult_req), 32'd0);
         end else begin
            chk("req_held", 32'(mult_req), 32'd1);
            chk("mult1_stable", mult1, prev_m1);
            chk("mult2_stable", mult2, prev_m2);
         end
      end
      prev_ok  = !rst;
      prev_req = mult_req;
      prev_ack = mult_ack;
      prev_m1  = mult1;
      prev_m2  = mult2;
   end

   // ---------------- stimulus ----------------
   // caller is at a negedge; returns at the negedge after donecp
   task automatic run_main(input logic [N-1:0] xv, input logic [CW-1:0] cv,
                           input logic [N-1:0] e, input int poke_at);
      int target;
      target = n_done + 1;
      x = xv;
      coeff = cv;
      startcp = 1'b1;
      wait_acc = 0;
      start_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      startcp = 1'b0;
      x = $urandom;
      coeff = {6{$urandom}};
      #1;
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_sum_clear", sum, '0);
      for (int i = 2; i < 300 && n_done < target; i++) begin
         @(negedge clk);
         startcp = (i == poke_at);
         if (i == poke_at) x = $urandom;
      end
      startcp = 1'b0;
      if (n_done < target) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no donecp expected one within 300 cycles");
      end
   endtask

   task automatic run_side(input int which, input logic [N-1:0] xv, input logic [CW-1:0] cv,
                           input logic [N-1:0] e, input int lat);
      int s;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      s = cyc;
      if (which == 0) begin xb = xv; coeffb = cv; startb = 1'b1; end
      else begin xc = xv; coeffc = cv[2*N-1:0]; startc = 1'b1; end
      @(negedge clk);
      startb = 1'b0;
      startc = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1;
         if (which == 0 && doneb) begin
            seen = 1'b1;
            chk("nosat_sum", sumb, e);
            chk("nosat_done_cycle", 32'(cyc - s), 32'(lat));
         end
         if (which == 1 && donec) begin
            seen = 1'b1;
            chk("ord1_sum", sumc, e);
            chk("ord1_done_cycle", 32'(cyc - s), 32'(lat));
         end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL side_timeout: got no donecp expected one (instance %0d)", which);
      end
   endtask

   initial begin
      logic [N-1:0]  xr;
      logic [CW-1:0] cr;
      #200000;
      $display("FAIL global_timeout: got no finish expected end of run");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0]  xr;
      logic [CW-1:0] cr;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_sum", sum, '0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_donecp", 32'(donecp), 32'd0);
      chk("rst_mult_req", 32'(mult_req), 32'd0);
      chk("rst_mult1", mult1, '0);
      chk("rst_mult2", mult2, '0);
      @(negedge clk);

      // directed, zero-wait multiplier
      run_main(HALF, mk(ONE, 0, 0, 0, 0, 0), 32'h0001_0000, 0);
      run_main(HALF, mk(0, 0, 0, 0, 0, ONE), 32'h0000_8000, 0);
      run_main(32'h8000_8000, mk(0, 0, 0, 0, 0, ONE), 32'h8000_8000, 0);
      run_main(HALF, mk(ONE, ONE, ONE, ONE, ONE, ONE), 32'h0000_0000, 0);
      run_main(ONE, mk(32'h7FFF_0000, 32'h7FFF_0000, 0, 0, 0, 0), 32'h7FFF_FFFF, 0);

      // delayed acks, spurious acks while idle, and a start pulse while busy
      max_wait = 3;
      spurious_en = 1'b1;
      run_main(HALF, mk(0, 0, 0, 0, 0, ONE), 32'h0000_8000, 0);
      run_main(HALF, mk(0, 0, 0, 0, 0, ONE), 32'h0000_8000, 9);

      // random operands against the reference model
      for (int n = 0; n < 8; n++) begin
         max_wait = $urandom_range(3, 0);
         xr = rnd_word(32'h1FFFF);
         for (int j = 0; j <= ORD; j++) cr[j*N +: N] = rnd_word(32'h3FFFF);
         run_main(xr, cr, ref_eval(xr, cr, ORD, 1'b1), (n % 2 == 0) ? 6 + n : 0);
      end

      // abort during the first ADD_T (cycle 7), then rerun
      max_wait = 0;
      spurious_en = 1'b0;
      x = HALF;
      coeff = mk(ONE, ONE, 0, 0, 0, ONE);
      startcp = 1'b1;
      @(negedge clk);
      startcp = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_sum", sum, '0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_donecp", 32'(donecp), 32'd0);
      chk("abort_mult_req", 32'(mult_req), 32'd0);
      chk("abort_mult1", mult1, '0);
      chk("abort_mult2", mult2, '0);
      @(negedge clk);
      run_main(HALF, mk(0, 0, 0, 0, 0, ONE), 32'h0000_8000, 0);

      // wrapping adder build and first-order build
      run_side(0, ONE, mk(32'h7FFF_0000, 32'h7FFF_0000, 0, 0, 0, 0), 32'h7FFE_0000, 22);
      run_side(1, 32'h0000_4000, {128'b0, ONE, ONE}, 32'h0001_4000, 6);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
